// File: rtl/trade_report_framer_pkg.sv
// -----------------------------------------------------------------------------
// trade_report_framer_pkg
// Shared constants for the trade report framer: default frame delimiters,
// trade action encodings and the framing FSM state type.
// Optional feature macro: TRADE_FRAMER_CHECKSUM_EN adds the CSUM state and the
// checksum accumulation helper.
// -----------------------------------------------------------------------------
package trade_report_framer_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hAA;
    localparam logic [7:0] FOOTER_DEFAULT = 8'h55;

    // Action encodings, zero-extended to a byte.
    localparam logic [7:0] ACT_NONE  = 8'd0;
    localparam logic [7:0] ACT_BUY_A = 8'd1;
    localparam logic [7:0] ACT_BUY_B = 8'd2;

    // The header byte is issued on the IDLE exit, so there is no separate
    // header-holding state.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACT  = 3'd1,
        ST_PRF  = 3'd2,
`ifdef TRADE_FRAMER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_FTR  = 3'd4
    } state_t;

`ifdef TRADE_FRAMER_CHECKSUM_EN
    // Running XOR checksum over the action byte and every profit byte.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

endpackage

// File: rtl/trade_report_framer_if.sv
// -----------------------------------------------------------------------------
// trade_report_framer_if
// Bundles the trade-decision input strobe and the uart_tx byte handshake.
//   trade_valid / trade_action / profit : decision from trade_strategy
//   tx_busy                             : uart_tx busy indication
//   tx_en / tx_data                     : one-cycle transmit pulse and byte
// Modports: master = framer side, slave = strategy/uart side.
// -----------------------------------------------------------------------------
interface trade_report_framer_if #(
    parameter int ACTION_W = 2,
    parameter int PROFIT_W = 16
);
    logic                trade_valid;
    logic [ACTION_W-1:0] trade_action;
    logic [PROFIT_W-1:0] profit;
    logic                tx_busy;
    logic                tx_en;
    logic [7:0]          tx_data;

    modport master (
        input  trade_valid, trade_action, profit, tx_busy,
        output tx_en, tx_data
    );

    modport slave (
        output trade_valid, trade_action, profit, tx_busy,
        input  tx_en, tx_data
    );
endinterface

// File: rtl/trade_report_framer_fifo.sv
// -----------------------------------------------------------------------------
// trade_fifo
// Synchronous FIFO holding pending trades.
//   clk, rst (async active-low)
//   push_i, data_i : write request; accepted when not full or when pop_i is high
//   pop_i          : remove the head entry (ignored when empty)
//   head_o         : current head entry
//   level_o        : occupancy, full_o: level == DEPTH, empty_o: level == 0
// -----------------------------------------------------------------------------
module trade_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             full_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok_s = push_i && (!full_q || pop_i);
    assign pop_ok_s  = pop_i && (level_q != {LW{1'b0}});

    // Occupancy next-state.
    always_comb begin
        level_d = level_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase
    end

    // Pointers, occupancy and full flag; pointers wrap since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
            full_q   <= 1'b0;
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = full_q;
    assign empty_o = (level_q == {LW{1'b0}});
endmodule

// File: rtl/trade_report_framer.sv
// -----------------------------------------------------------------------------
// trade_report_framer
// Queues trade decisions and serialises each as a framed byte stream into
// uart_tx, one byte per issue slot:
//   HEADER, action byte, profit bytes MSB first, [checksum], FOOTER.
// Ports:
//   clk, rst (async active-low)
//   bus (master modport): trade_valid/trade_action/profit in, tx_busy in,
//                         tx_en/tx_data out
//   queue_level : FIFO occupancy
//   queue_full  : queue_level == QUEUE_DEPTH
//   drop_count  : trades lost to a full queue, saturating at 255
// Optional feature macro: TRADE_FRAMER_CHECKSUM_EN inserts an XOR checksum
// byte (action byte and profit bytes only) before the footer.
// -----------------------------------------------------------------------------
module trade_report_framer
    import trade_report_framer_pkg::*;
#(
    parameter int         PROFIT_W    = 16,
    parameter int         ACTION_W    = 2,
    parameter int         QUEUE_DEPTH = 4,
    parameter logic [7:0] HEADER      = HEADER_DEFAULT,
    parameter logic [7:0] FOOTER      = FOOTER_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    trade_report_framer_if.master         bus,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_level,
    output logic                          queue_full,
    output logic [7:0]                    drop_count
);
    localparam int NB    = PROFIT_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int FW    = ACTION_W + PROFIT_W;

    state_t           state_q, state_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic             tx_en_q, tx_en_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       drop_q, drop_d;
`ifdef TRADE_FRAMER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             push_req_s, space_s, push_s, pop_s, slot_s;
    logic             full_s, empty_s;
    logic [FW-1:0]    head_s;
    logic [7:0]       act_byte_s, prf_byte_s;

    assign push_req_s = bus.trade_valid && (8'(bus.trade_action) != ACT_NONE);
    assign space_s    = !full_s || pop_s;
    assign push_s     = push_req_s && space_s;
    // tx_busy only rises the cycle after tx_en, so tx_en itself blocks the next slot.
    assign slot_s     = !bus.tx_busy && !tx_en_q;

    trade_fifo #(
        .WIDTH (FW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  ({bus.trade_action, bus.profit}),
        .head_o  (head_s),
        .level_o (queue_level),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Byte views of the frame register: zero-extended action and selected profit byte.
    always_comb begin
        act_byte_s                 = 8'h00;
        act_byte_s[ACTION_W-1:0]   = frame_q[FW-1 -: ACTION_W];
        prf_byte_s                 = frame_q[{byte_idx_q, 3'b000} +: 8];
    end

    // Framing FSM next-state, byte issue and FIFO pop.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        byte_idx_d = byte_idx_q;
        tx_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        pop_s      = 1'b0;
`ifdef TRADE_FRAMER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (slot_s && !empty_s) begin
                    pop_s     = 1'b1;
                    frame_d   = head_s;
                    tx_en_d   = 1'b1;
                    tx_data_d = HEADER;
                    state_d   = ST_ACT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ACT: begin
                if (slot_s) begin
                    tx_en_d    = 1'b1;
                    tx_data_d  = act_byte_s;
                    byte_idx_d = IDX_W'(NB - 1);
`ifdef TRADE_FRAMER_CHECKSUM_EN
                    csum_d     = act_byte_s;
`endif
                    state_d    = ST_PRF;
                end else begin
                    state_d    = ST_ACT;
                end
            end
            ST_PRF: begin
                if (slot_s) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = prf_byte_s;
`ifdef TRADE_FRAMER_CHECKSUM_EN
                    csum_d    = csum_step(csum_q, prf_byte_s);
`endif
                    if (byte_idx_q == {IDX_W{1'b0}}) begin
`ifdef TRADE_FRAMER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_FTR;
`endif
                    end else begin
                        byte_idx_d = byte_idx_q - IDX_W'(1'b1);
                    end
                end else begin
                    state_d = ST_PRF;
                end
            end
`ifdef TRADE_FRAMER_CHECKSUM_EN
            ST_CSUM: begin
                if (slot_s) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = csum_q;
                    state_d   = ST_FTR;
                end else begin
                    state_d   = ST_CSUM;
                end
            end
`endif
            ST_FTR: begin
                if (slot_s) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = FOOTER;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_FTR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating drop counter: a real trade with no space this cycle is lost.
    always_comb begin
        if (push_req_s && !space_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            frame_q    <= {FW{1'b0}};
            byte_idx_q <= {IDX_W{1'b0}};
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            drop_q     <= 8'h00;
`ifdef TRADE_FRAMER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            byte_idx_q <= byte_idx_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            drop_q     <= drop_d;
`ifdef TRADE_FRAMER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.tx_en   = tx_en_q;
    assign bus.tx_data = tx_data_q;
    assign queue_full  = full_s;
    assign drop_count  = drop_q;
endmodule
